regfile_writeback_arbiter: RTL

- Drives the register file write port (rd, write_data, reg_write), merging two result sources:
  - the single-cycle ALU/load writeback path;
  - a long-latency result path (multi-cycle mul/div or memory unit) with a valid/ready handshake.
- Long-path results wait in a small FIFO and drain whenever the ALU path leaves the write port idle.
- A 32-entry busy scoreboard lets decode stall on operands or destinations that still have long-latency writes pending.

---
 rtl/rv_pkg.sv | 13 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_writeback_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback entry carried by the long-latency path.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_entry_t        wdata_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, doPush, doPop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full;
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: ALU results win, buffered long-latency results
// drain into idle slots, and a busy scoreboard stalls decode on pending long writes.
module regfile_writeback_arbiter
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall,
  input  logic                  alu_we,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lw_valid,
  output logic                  lw_ready,
  input  logic [REG_ADDR_W-1:0] lw_rd,
  input  logic [XLEN-1:0]       lw_data,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       write_data,
  output logic                  reg_write
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  wb_entry_t           head, pushEntry;
  logic                fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic                aluWins, drain, push, reserve;

  assign pushEntry = '{rd: lw_rd, data: lw_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (drain),
    .wdata_i (pushEntry),
    .head_o  (head),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // An ALU write to x0 leaves the port idle so the FIFO can use the slot.
  assign aluWins  = alu_we && (alu_rd != X0);
  assign drain    = rst_n && !aluWins && !fifoEmpty;
  assign lw_ready = rst_n && (fifoCount < CNT_W'(FIFO_DEPTH));
  assign push     = lw_valid && lw_ready;

  assign stall   = rst_n && iss_valid &&
                   (((rs1 != X0) && busy_q[rs1]) ||
                    ((rs2 != X0) && busy_q[rs2]) ||
                    ((iss_rd != X0) && busy_q[iss_rd]));
  assign reserve = iss_valid && iss_long && !stall && (iss_rd != X0);

  // A drained x0 entry is popped silently without touching the register file.
  always_comb begin
    rd         = '0;
    write_data = '0;
    reg_write  = 1'b0;
    if (rst_n) begin
      if (aluWins) begin
        rd         = alu_rd;
        write_data = alu_data;
        reg_write  = 1'b1;
      end else if (!fifoEmpty && (head.rd != X0)) begin
        rd         = head.rd;
        write_data = head.data;
        reg_write  = 1'b1;
      end
    end
  end

  // Reservation is applied after the drain clear so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (drain)   busy_d[head.rd] = 1'b0;
    if (reserve) busy_d[iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end
endmodule
